// File: rtl/cascade_mod_counter.sv
// cascade_mod_counter: chain of NUM_DIGITS mod-N digit counters, each digit with
// its own modulus. Up/down counting, synchronous clear, parallel load with
// clamping, and wrap or saturate behaviour at the terminal value.
// Feeds the seven-segment display mux from the stopwatch tick generator.
module cascade_mod_counter #(
    parameter int          NUM_DIGITS = 4,
    parameter int          DIGIT_W    = 4,
    parameter logic [63:0] MODS       = 64'h0000_0000_060A_0A0A,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   load_value,
    input  logic                            increment,
    input  logic                            down,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   count,
    output logic [NUM_DIGITS-1:0]           digit_carry,
    output logic                            carry_out,
    output logic                            at_terminal,
    output logic                            ovf_sticky
);

    localparam int CW = NUM_DIGITS * DIGIT_W;

    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;
    logic                  ovf_reg;
    logic                  ovf_next;

    // match: digit sits at its terminal value for the current direction
    // chain: all digits 0..i are at terminal (prefix AND of match)
    // step:  digit i advances this cycle
    logic [NUM_DIGITS-1:0] match;
    logic [NUM_DIGITS-1:0] chain;
    logic [NUM_DIGITS-1:0] step;
    logic                  suppress;
    logic                  sat_hit;

    genvar gi;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("cascade_mod_counter: NUM_DIGITS must be in 1..8");
    end

    // Whole chain at terminal: all digits at MOD-1 counting up, all zero counting down.
    assign at_terminal = chain[NUM_DIGITS-1];

    // Clear and load swallow the increment; in saturate mode so does the terminal value.
    assign suppress = clear | load | (SATURATE & at_terminal);

    // A saturation hit is an accepted increment while pinned at the terminal value.
    assign sat_hit = SATURATE & increment & at_terminal & ~clear & ~load;

    // In saturate mode the top carry can never fire, so carry_out is tied low there.
    assign carry_out = SATURATE ? 1'b0 : digit_carry[NUM_DIGITS-1];

    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        localparam int                 MOD_I = int'(MODS[8*gi +: 8]);
        localparam logic [DIGIT_W-1:0] TOP   = DIGIT_W'(MOD_I - 1);

        logic [DIGIT_W-1:0] cur;
        logic [DIGIT_W-1:0] lv;
        logic [DIGIT_W-1:0] nxt;

        if (MOD_I < 2 || MOD_I > (2 ** DIGIT_W)) begin : g_bad_mod
            $error("cascade_mod_counter: digit modulus out of range 2..2**DIGIT_W");
        end

        assign cur = count_reg[DIGIT_W*gi +: DIGIT_W];
        assign lv  = load_value[DIGIT_W*gi +: DIGIT_W];

        assign match[gi] = down ? (cur == '0) : (cur == TOP);
        assign chain[gi] = &match[gi:0];

        if (gi == 0) begin : g_lsd
            assign step[gi] = increment & ~suppress;
        end else begin : g_upper
            assign step[gi] = increment & ~suppress & chain[gi-1];
        end

        assign digit_carry[gi] = increment & ~suppress & chain[gi];

        // Next digit value: clear, then clamped load, then wrap or +/-1 when stepping.
        always_comb begin
            nxt = cur;
            if (clear) begin
                nxt = '0;
            end else if (load) begin
                nxt = (lv > TOP) ? TOP : lv;
            end else if (step[gi]) begin
                if (digit_carry[gi]) begin
                    nxt = down ? TOP : '0;
                end else begin
                    nxt = down ? (cur - 1'b1) : (cur + 1'b1);
                end
            end
        end

        assign count_next[DIGIT_W*gi +: DIGIT_W] = nxt;
    end

    // Sticky overflow: set on a full-chain wrap or saturation hit, cleared only by clear.
    always_comb begin
        ovf_next = ovf_reg;
        if (clear) begin
            ovf_next = 1'b0;
        end else if (carry_out | sat_hit) begin
            ovf_next = 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign count      = count_reg;
    assign ovf_sticky = ovf_reg;

endmodule

// File: tb/tb_cascade_mod_counter.sv
// Testbench for cascade_mod_counter: one wrapping and one saturating instance
// share stimulus; a mixed-radix integer model predicts both.
module tb_cascade_mod_counter;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        load;
    logic [15:0] load_value;
    logic        increment;
    logic        down;

    logic [15:0] count_w, count_s;
    logic [3:0]  dc_w, dc_s;
    logic        co_w, co_s, at_w, at_s, ovf_w, ovf_s;

    int tests  = 0;
    int errors = 0;

    // Model: counter held as one integer in 0..TOTAL-1
    localparam int TOTAL = 6000;
    int mods [4] = '{10, 10, 10, 6};
    int wts  [4] = '{1, 10, 100, 1000};
    int val_w, val_s;
    logic ovf_mw, ovf_ms;

    cascade_mod_counter #(.SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
        .increment(increment), .down(down), .count(count_w), .digit_carry(dc_w),
        .carry_out(co_w), .at_terminal(at_w), .ovf_sticky(ovf_w)
    );

    cascade_mod_counter #(.SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
        .increment(increment), .down(down), .count(count_s), .digit_carry(dc_s),
        .carry_out(co_s), .at_terminal(at_s), .ovf_sticky(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_digits(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / wts[i]) % mods[i]);
        return r;
    endfunction

    function automatic int from_load(input logic [15:0] lv);
        int v = 0;
        for (int i = 0; i < 4; i++) begin
            int d = int'(lv[4*i +: 4]);
            if (d >= mods[i]) d = mods[i] - 1;
            v += d * wts[i];
        end
        return v;
    endfunction

    function automatic logic is_term(input int v, input logic dn);
        return dn ? (v == 0) : (v == TOTAL - 1);
    endfunction

    // Digit i carries when the low-order part (v mod prod of mods 0..i) is at its extreme.
    function automatic logic [3:0] exp_dc(input int v, input logic inc, input logic dn, input logic blocked);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            int m = wts[i] * mods[i];
            r[i] = inc & ~blocked & (dn ? ((v % m) == 0) : ((v % m) == m - 1));
        end
        return r;
    endfunction

    task automatic cyc(input logic c, input logic l, input logic [15:0] lv, input logic inc, input logic dn);
        logic [3:0] e_w, e_s;
        @(negedge clk);
        clear = c; load = l; load_value = lv; increment = inc; down = dn;
        #1;
        e_w = exp_dc(val_w, inc, dn, c | l);
        e_s = exp_dc(val_s, inc, dn, c | l | is_term(val_s, dn));
        check("dc_wrap", 32'(dc_w), 32'(e_w));
        check("co_wrap", 32'(co_w), 32'(e_w[3]));
        check("term_wrap", 32'(at_w), 32'(is_term(val_w, dn)));
        check("dc_sat", 32'(dc_s), 32'(e_s));
        check("co_sat", 32'(co_s), 32'd0);
        check("term_sat", 32'(at_s), 32'(is_term(val_s, dn)));
        @(posedge clk);
        if (c) begin
            val_w = 0; ovf_mw = 1'b0; val_s = 0; ovf_ms = 1'b0;
        end else if (l) begin
            val_w = from_load(lv); val_s = from_load(lv);
        end else if (inc) begin
            if (e_w[3]) ovf_mw = 1'b1;
            val_w = dn ? (val_w + TOTAL - 1) % TOTAL : (val_w + 1) % TOTAL;
            if (is_term(val_s, dn)) ovf_ms = 1'b1;
            else val_s = dn ? val_s - 1 : val_s + 1;
        end
        #1;
        check("count_wrap", 32'(count_w), 32'(to_digits(val_w)));
        check("ovf_wrap", 32'(ovf_w), 32'(ovf_mw));
        check("count_sat", 32'(count_s), 32'(to_digits(val_s)));
        check("ovf_sat", 32'(ovf_s), 32'(ovf_ms));
        $display("[TB] clr=%0b ld=%0b lv=%h inc=%0b dn=%0b -> wrap=%h ovf=%0b sat=%h ovf=%0b",
                 c, l, lv, inc, dn, count_w, ovf_w, count_s, ovf_s);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0; increment = 1'b0; down = 1'b0;
        val_w = 0; val_s = 0; ovf_mw = 1'b0; ovf_ms = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_count", 32'(count_w), 32'd0);
        check("reset_ovf", 32'(ovf_w), 32'd0);

        // T3: wrap from 5999
        cyc(0, 1, 16'h5999, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0);
        check("T3_count", 32'(count_w), 32'h0000);
        check("T3_ovf", 32'(ovf_w), 32'd1);
        cyc(0, 0, 16'h0000, 0, 0);
        check("T3_ovf_hold", 32'(ovf_w), 32'd1);

        // T1: asynchronous reset mid-cycle at 1234
        cyc(0, 1, 16'h1234, 0, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("T1_count", 32'(count_w), 32'd0);
        check("T1_ovf", 32'(ovf_w), 32'd0);
        check("T1_count_sat", 32'(count_s), 32'd0);
        #1 reset = 1'b0;
        val_w = 0; val_s = 0; ovf_mw = 1'b0; ovf_ms = 1'b0;

        // T2: up cascade 0999 -> 1000
        cyc(0, 1, 16'h0999, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0);
        check("T2_count", 32'(count_w), 32'h1000);

        // T4: down borrow, then down-wrap from 0000
        cyc(0, 1, 16'h1000, 0, 1);
        cyc(0, 0, 16'h0000, 1, 1);
        check("T4_borrow", 32'(count_w), 32'h0999);
        cyc(0, 1, 16'h0000, 0, 1);
        cyc(0, 0, 16'h0000, 1, 1);
        check("T4_wrap", 32'(count_w), 32'h5999);

        // T5: saturation
        cyc(1, 0, 16'h0000, 0, 0);
        cyc(0, 1, 16'h5998, 0, 0);
        cyc(0, 0, 16'h0000, 1, 0);
        check("T5_s1", 32'(count_s), 32'h5999);
        check("T5_ovf1", 32'(ovf_s), 32'd0);
        cyc(0, 0, 16'h0000, 1, 0);
        check("T5_s2", 32'(count_s), 32'h5999);
        check("T5_ovf2", 32'(ovf_s), 32'd1);
        cyc(0, 0, 16'h0000, 1, 0);
        check("T5_s3", 32'(count_s), 32'h5999);

        // T6: priority and clamp
        cyc(1, 1, 16'h1234, 1, 0);
        check("T6_clear", 32'(count_w), 32'h0000);
        cyc(0, 1, 16'h7A9C, 0, 0);
        check("T6_clamp", 32'(count_w), 32'h5999);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r = int'($urandom_range(0, 99));
            logic [15:0] lv;
            logic dn;
            dn = ($urandom_range(0, 7) == 0) ? ~down : down;
            if (r < 3) begin
                cyc(1, $urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1, dn);
            end else if (r < 10) begin
                case ($urandom_range(0, 2))
                    0:       lv = 16'($urandom);
                    1:       lv = 16'h5997;
                    default: lv = 16'h0002;
                endcase
                cyc(0, 1, lv, $urandom_range(0, 1) == 1, dn);
            end else begin
                cyc(0, 0, 16'h0000, $urandom_range(0, 9) < 8, dn);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
